// File: rtl/dmem_responder.sv
// Memory-stage data responder: byte-lane RAM plus a small MMIO block
// (GPIO, cycle counter, sticky misaligned-store error with captured address).
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic [31:0] gpio_out,
  output logic        misalign_err,
  output logic [31:0] err_addr
);
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  // Handshake: none. A store is a single-cycle strobe (MemWriteM) committed at
  // the rising edge; loads are purely combinational with no strobe.

  logic [31:0] mem [DEPTH];
  logic [31:0] gpioReg;
  logic [31:0] cycleCnt;
  logic [31:0] errAddrReg;
  logic        errFlag;

  logic          isRam;
  logic          isMmio;
  logic [AW-1:0] wordIdx;
  logic [1:0]    byteOff;
  logic [1:0]    mmioSel;

  assign byteOff = Mem_WrAddr[1:0];
  assign mmioSel = Mem_WrAddr[3:2];
  assign wordIdx = Mem_WrAddr[AW+1:2];
  assign isRam   = (Mem_WrAddr < RAM_BYTES);
  assign isMmio  = (Mem_WrAddr[31:4] == MMIO_BASE[31:4]);

  // Store lane generation: data is replicated across lanes, the mask picks one.
  logic [3:0]  laneMask;
  logic [31:0] laneData;
  logic [31:0] bitMask;
  logic        legalStore;
  logic        misaligned;
  logic        storeEn;
  logic        misStore;

  always_comb begin
    laneMask   = 4'b0000;
    laneData   = Mem_WrData;
    legalStore = 1'b0;
    misaligned = 1'b0;
    case (funct3M)
      3'b000: begin
        legalStore = 1'b1;
        laneMask   = 4'b0001 << byteOff;
        laneData   = {4{Mem_WrData[7:0]}};
      end
      3'b001: begin
        legalStore = 1'b1;
        laneMask   = byteOff[1] ? 4'b1100 : 4'b0011;
        laneData   = {2{Mem_WrData[15:0]}};
        misaligned = byteOff[0];
      end
      3'b010: begin
        legalStore = 1'b1;
        laneMask   = 4'b1111;
        misaligned = (byteOff != 2'b00);
      end
      default: ;
    endcase
  end

  assign bitMask  = {{8{laneMask[3]}}, {8{laneMask[2]}}, {8{laneMask[1]}}, {8{laneMask[0]}}};
  assign storeEn  = MemWriteM & legalStore & ~misaligned;
  assign misStore = MemWriteM & legalStore & misaligned;

  logic gpioWr;
  logic statusClr;
  assign gpioWr    = storeEn & ~isRam & isMmio & (mmioSel == 2'd0);
  assign statusClr = storeEn & ~isRam & isMmio & (mmioSel == 2'd2) & laneMask[0] & laneData[0];

  // RAM has no reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && storeEn && isRam) begin
      for (int b = 0; b < 4; b++) begin
        if (laneMask[b]) mem[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpioReg    <= 32'h0;
      cycleCnt   <= 32'h0;
      errFlag    <= 1'b0;
      errAddrReg <= 32'h0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (gpioWr) gpioReg <= (gpioReg & ~bitMask) | (laneData & bitMask);
      errFlag <= misStore | (errFlag & ~statusClr);
      // A clear in the same cycle counts as "flag was empty", so capture again.
      if (misStore && (!errFlag || statusClr)) errAddrReg <= Mem_WrAddr;
    end
  end

  logic [31:0] srcWord;
  logic [7:0]  selByte;
  logic [15:0] selHalf;

  always_comb begin
    srcWord = 32'h0;
    if (isRam) begin
      srcWord = mem[wordIdx];
    end else if (isMmio) begin
      case (mmioSel)
        2'd0:    srcWord = gpioReg;
        2'd1:    srcWord = cycleCnt;
        2'd2:    srcWord = {31'b0, errFlag};
        default: srcWord = errAddrReg;
      endcase
    end
  end

  always_comb begin
    selByte = srcWord[7:0];
    case (byteOff)
      2'd1:    selByte = srcWord[15:8];
      2'd2:    selByte = srcWord[23:16];
      2'd3:    selByte = srcWord[31:24];
      default: selByte = srcWord[7:0];
    endcase
    selHalf = byteOff[1] ? srcWord[31:16] : srcWord[15:0];
    case (funct3M)
      3'b000:  ReadData = {{24{selByte[7]}}, selByte};
      3'b001:  ReadData = {{16{selHalf[15]}}, selHalf};
      3'b100:  ReadData = {24'b0, selByte};
      3'b101:  ReadData = {16'b0, selHalf};
      default: ReadData = srcWord;
    endcase
  end

  assign gpio_out     = gpioReg;
  assign misalign_err = errFlag;
  assign err_addr     = errAddrReg;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic checked
// against a byte-addressed reference model.
module tb_dmem_responder;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_A    = MMIO_BASE;
  localparam logic [31:0] CYCLE_A   = MMIO_BASE + 32'h4;
  localparam logic [31:0] STATUS_A  = MMIO_BASE + 32'h8;
  localparam logic [31:0] ERRADDR_A = MMIO_BASE + 32'hC;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic [31:0] gpio_out;
  logic        misalign_err;
  logic [31:0] err_addr;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.DEPTH(1024), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData), .ReadData(ReadData),
    .gpio_out(gpio_out), .misalign_err(misalign_err), .err_addr(err_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // reference model: memory seen as individually addressed bytes
  logic [31:0] m_mem [int];
  logic [31:0] m_gpio     = 32'h0;
  logic [31:0] m_err_addr = 32'h0;
  logic        m_err      = 1'b0;

  function automatic logic [31:0] m_word(input logic [31:0] a);
    if (a < 32'd4096) begin
      if (m_mem.exists(int'(a / 4))) return m_mem[int'(a / 4)];
      return 32'h0;
    end
    if (a >= MMIO_BASE && (a - MMIO_BASE) < 32'd16) begin
      case (int'((a - MMIO_BASE) / 4))
        0:       return m_gpio;
        2:       return {31'b0, m_err};
        3:       return m_err_addr;
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = m_word(a);
    b = 8'(w >> (8 * (a % 4)));
    h = 16'(w >> (16 * ((a / 2) % 2)));
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'b0, b};
      3'd5:    return {16'b0, h};
      default: return w;
    endcase
  endfunction

  task automatic m_write_byte(input logic [31:0] ba, input logic [7:0] v);
    logic [31:0] w;
    int sh;
    sh = 8 * int'(ba % 4);
    if (ba < 32'd4096) begin
      w = m_mem.exists(int'(ba / 4)) ? m_mem[int'(ba / 4)] : 32'h0;
      w = (w & ~(32'hFF << sh)) | (32'(v) << sh);
      m_mem[int'(ba / 4)] = w;
    end else if (ba >= GPIO_A && ba < GPIO_A + 32'd4) begin
      m_gpio = (m_gpio & ~(32'hFF << sh)) | (32'(v) << sh);
    end else if (ba == STATUS_A && v[0]) begin
      m_err = 1'b0;
    end
  endtask

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int size;
    if (f3 > 3'd2) return;
    size = 1 << f3;
    if ((a % size) != 0) begin
      if (!m_err) m_err_addr = a;
      m_err = 1'b1;
      return;
    end
    for (int i = 0; i < size; i++) m_write_byte(a + 32'(i), d[8*i +: 8]);
  endtask

  // driver tasks: called mid-cycle, stores commit on the next rising edge
  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    MemWriteM  = 1'b1;
    funct3M    = f3;
    Mem_WrAddr = a;
    Mem_WrData = d;
    @(posedge clk);
    m_store(f3, a, d);
    #1;
    MemWriteM = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, output logic [31:0] r);
    MemWriteM  = 1'b0;
    funct3M    = f3;
    Mem_WrAddr = a;
    #1;
    r = ReadData;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    reset = 1'b1; MemWriteM = 1'b0; funct3M = 3'd2; Mem_WrAddr = 32'h0; Mem_WrData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio got=%h exp=0", gpio_out); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", misalign_err); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_erraddr got=%h exp=0", err_addr); end
    do_load(3'd2, CYCLE_A, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_cycle got=%h exp=0", r); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_cycle;
    logic [31:0] r;
    repeat (10) @(posedge clk);
    #1;
    do_load(3'd2, CYCLE_A, r);
    checks++; if (r !== 32'd10) begin errors++; $display("FAIL cycle_after_10 got=%0d exp=10", r); end
  endtask

  task automatic init_ram;
    for (int w = 0; w < 16; w++) do_store(3'd2, 32'(w * 4), $urandom);
  endtask

  task automatic test_basic_ram;
    logic [31:0] r;
    do_store(3'd2, 32'h10, 32'h1122_3344);
    do_load(3'd0, 32'h13, r);
    checks++; if (r !== 32'h0000_0011) begin errors++; $display("FAIL lb_13 got=%h exp=00000011", r); end
    do_load(3'd0, 32'h10, r);
    checks++; if (r !== 32'h0000_0044) begin errors++; $display("FAIL lb_10 got=%h exp=00000044", r); end
    do_load(3'd1, 32'h12, r);
    checks++; if (r !== 32'h0000_1122) begin errors++; $display("FAIL lh_12 got=%h exp=00001122", r); end
    do_load(3'd2, 32'h10, r);
    checks++; if (r !== 32'h1122_3344) begin errors++; $display("FAIL lw_10 got=%h exp=11223344", r); end
  endtask

  task automatic test_lanes;
    logic [31:0] r;
    do_store(3'd2, 32'h20, 32'h0);
    do_store(3'd0, 32'h21, 32'hFFFF_FF80);
    do_load(3'd2, 32'h20, r);
    checks++; if (r !== 32'h0000_8000) begin errors++; $display("FAIL sb_lw_20 got=%h exp=00008000", r); end
    do_load(3'd0, 32'h21, r);
    checks++; if (r !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_21 got=%h exp=ffffff80", r); end
    do_load(3'd4, 32'h21, r);
    checks++; if (r !== 32'h0000_0080) begin errors++; $display("FAIL lbu_21 got=%h exp=00000080", r); end
    do_store(3'd1, 32'h22, 32'h1234_BEEF);
    do_load(3'd5, 32'h22, r);
    checks++; if (r !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_22 got=%h exp=0000beef", r); end
    do_load(3'd1, 32'h22, r);
    checks++; if (r !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_22 got=%h exp=ffffbeef", r); end
    do_load(3'd1, 32'h23, r);
    checks++; if (r !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_23_odd got=%h exp=ffffbeef", r); end
    do_load(3'd2, 32'h22, r);
    checks++; if (r !== 32'hBEEF_8000) begin errors++; $display("FAIL lw_22_ignore_low got=%h exp=beef8000", r); end
  endtask

  task automatic test_same_cycle;
    MemWriteM = 1'b1; funct3M = 3'd2; Mem_WrAddr = 32'h10; Mem_WrData = 32'hCAFE_F00D;
    #1;
    checks++; if (ReadData !== 32'h1122_3344) begin errors++; $display("FAIL same_cycle_old got=%h exp=11223344", ReadData); end
    @(posedge clk);
    m_store(3'd2, 32'h10, 32'hCAFE_F00D);
    #1;
    MemWriteM = 1'b0;
    #1;
    checks++; if (ReadData !== 32'hCAFE_F00D) begin errors++; $display("FAIL next_cycle_new got=%h exp=cafef00d", ReadData); end
  endtask

  task automatic test_misalign;
    logic [31:0] r;
    logic [31:0] exp;
    exp = m_load(3'd2, 32'h04);
    do_store(3'd2, 32'h06, 32'hDEAD_BEEF);
    do_load(3'd2, 32'h04, r);
    checks++; if (r !== exp) begin errors++; $display("FAIL misal_ram_unchanged got=%h exp=%h", r, exp); end
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misal_set got=%b exp=1", misalign_err); end
    checks++; if (err_addr !== 32'h06) begin errors++; $display("FAIL misal_addr got=%h exp=6", err_addr); end
    do_store(3'd1, 32'h09, 32'h5555);
    checks++; if (err_addr !== 32'h06) begin errors++; $display("FAIL misal_first_held got=%h exp=6", err_addr); end
    do_load(3'd2, STATUS_A, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL status_read got=%h exp=1", r); end
    do_load(3'd2, ERRADDR_A, r);
    checks++; if (r !== 32'h06) begin errors++; $display("FAIL erraddr_read got=%h exp=6", r); end
    do_store(3'd0, STATUS_A + 32'h1, 32'h01);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL clr_wrong_lane got=%b exp=1", misalign_err); end
    do_store(3'd2, STATUS_A, 32'hFFFF_FFFE);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL clr_bit0_zero got=%b exp=1", misalign_err); end
    do_store(3'd2, STATUS_A, 32'h1);
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL clr_sw got=%b exp=0", misalign_err); end
    do_store(3'd2, 32'h0B, 32'h0);
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL misal_reset got=%b exp=1", misalign_err); end
    checks++; if (err_addr !== 32'h0B) begin errors++; $display("FAIL misal_new_addr got=%h exp=b", err_addr); end
    do_store(3'd1, STATUS_A, 32'h0001);
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL clr_sh got=%b exp=0", misalign_err); end
    do_load(3'd2, 32'h07, r);
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL load_no_err got=%b exp=0", misalign_err); end
  endtask

  task automatic test_gpio;
    logic [31:0] r0;
    logic [31:0] r1;
    do_store(3'd2, GPIO_A, 32'hA5A5_A5A5);
    checks++; if (gpio_out !== 32'hA5A5_A5A5) begin errors++; $display("FAIL gpio_sw got=%h exp=a5a5a5a5", gpio_out); end
    do_store(3'd0, GPIO_A + 32'h1, 32'h3C);
    checks++; if (gpio_out !== 32'hA5A5_3CA5) begin errors++; $display("FAIL gpio_sb got=%h exp=a5a53ca5", gpio_out); end
    do_load(3'd2, CYCLE_A, r0);
    do_store(3'd2, CYCLE_A, 32'h1234_5678);
    do_load(3'd2, CYCLE_A, r1);
    checks++; if (r1 !== r0 + 32'd1) begin errors++; $display("FAIL cycle_ro got=%h exp=%h", r1, r0 + 32'd1); end
    do_store(3'd2, ERRADDR_A, 32'h7777_7777);
    checks++; if (err_addr !== m_err_addr) begin errors++; $display("FAIL erraddr_ro got=%h exp=%h", err_addr, m_err_addr); end
  endtask

  task automatic test_unmapped;
    logic [31:0] r;
    do_load(3'd2, 32'h8000_0000, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_lw got=%h exp=0", r); end
    do_load(3'd2, MMIO_BASE + 32'h10, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL past_mmio_lw got=%h exp=0", r); end
    do_store(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_store(3'd2, 32'h0000_1000, 32'hFFFF_FFFF);
    checks++; if (gpio_out !== m_gpio) begin errors++; $display("FAIL unmapped_gpio got=%h exp=%h", gpio_out, m_gpio); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL unmapped_err got=%b exp=0", misalign_err); end
    do_load(3'd2, 32'h8000_0000, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_after got=%h exp=0", r); end
  endtask

  task automatic test_random;
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] exp;
    logic [2:0]  f3;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = GPIO_A + 32'($urandom_range(0, 3));
        1:       a = STATUS_A + 32'($urandom_range(0, 7));
        default: a = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 1) == 0) begin
        f3 = 3'($urandom_range(0, 3));
        do_store(f3, a, $urandom);
        checks++; if (gpio_out !== m_gpio) begin errors++; $display("FAIL rnd_gpio n=%0d got=%h exp=%h", n, gpio_out, m_gpio); end
        checks++; if (misalign_err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, misalign_err, m_err); end
        checks++; if (err_addr !== m_err_addr) begin errors++; $display("FAIL rnd_erraddr n=%0d got=%h exp=%h", n, err_addr, m_err_addr); end
      end else begin
        f3 = 3'($urandom_range(0, 7));
        exp = m_load(f3, a);
        do_load(f3, a, r);
        checks++; if (r !== exp) begin errors++; $display("FAIL rnd_load n=%0d f3=%0d a=%h got=%h exp=%h", n, f3, a, r, exp); end
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] r;
    @(negedge clk);
    force dut.cycleCnt = 32'hFFFF_FFFF;
    do_load(3'd2, CYCLE_A, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_forced got=%h exp=ffffffff", r); end
    release dut.cycleCnt;
    @(posedge clk);
    #1;
    do_load(3'd2, CYCLE_A, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL cycle_wrap got=%h exp=0", r); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    logic [31:0] exp;
    do_store(3'd2, GPIO_A, 32'h5A5A_5A5A);
    do_store(3'd2, 32'h31, 32'h0);
    exp = m_load(3'd2, 32'h10);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL midrst_gpio got=%h exp=0", gpio_out); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b exp=0", misalign_err); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL midrst_erraddr got=%h exp=0", err_addr); end
    do_load(3'd2, CYCLE_A, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL midrst_cycle got=%h exp=0", r); end
    m_gpio = 32'h0; m_err = 1'b0; m_err_addr = 32'h0;
    MemWriteM = 1'b1; funct3M = 3'd2; Mem_WrAddr = 32'h10; Mem_WrData = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    MemWriteM = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_load(3'd2, 32'h10, r);
    checks++; if (r !== exp) begin errors++; $display("FAIL midrst_ram_kept got=%h exp=%h", r, exp); end
  endtask

  initial begin
    test_reset;
    test_cycle;
    init_ram;
    test_basic_ram;
    test_lanes;
    test_same_cycle;
    test_misalign;
    test_gpio;
    test_unmapped;
    test_random;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
